// File: rtl/rob_pkg.sv
// Shared reorder-buffer types, default sizes and mod-2^w pointer helpers.
package rob_pkg;

  localparam int unsigned ROB_DEPTH  = 64;
  localparam int unsigned ROB_IDX_W  = $clog2(ROB_DEPTH);
  localparam int unsigned ROB_PREG_W = 6;

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic                  exc;
    logic [ROB_PREG_W-1:0] dest;
    logic [ROB_PREG_W-1:0] old_dest;
    logic [4:0]            arch_dest;
    logic [31:0]           pc;
    logic [31:0]           value;
  } rob_entry_t;

  function automatic int unsigned ptr_add(int unsigned a, int unsigned n, int unsigned idx_w);
    return (a + n) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Distance from b forward to a on a ring of 2^idx_w slots.
  function automatic int unsigned ptr_dist(int unsigned a, int unsigned b, int unsigned idx_w);
    return (a - b) & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/rob_multiport_commit_select.sv
// Picks the contiguous run of retire-ready slots starting at head; an excepting
// entry is only ever retired alone in slot 0.
module rob_multiport_commit_select #(
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned CNT_W    = $clog2(COMMIT_W + 1)
) (
  input  logic [COMMIT_W-1:0] slot_rdy,
  input  logic [COMMIT_W-1:0] slot_exc,
  input  logic                commit_ready,
  input  logic                flush_valid,
  output logic [COMMIT_W-1:0] commit_valid,
  output logic [CNT_W-1:0]    commit_cnt
);

  logic run;

  always_comb begin
    commit_valid = '0;
    commit_cnt   = '0;
    run          = commit_ready && !flush_valid;
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      if (k != 0 && slot_exc[k]) run = 1'b0;
      run             = run && slot_rdy[k];
      commit_valid[k] = run;
      if (run) commit_cnt = commit_cnt + CNT_W'(1);
      if (k == 0 && slot_exc[0]) run = 1'b0;
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer: tag-indexed writeback, up to COMMIT_W in-order retirements, mispredict squash.
// Define ROB_EXCEPTION_EN to add per-entry exception flags and precise exception retirement.
module rob_multiport
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH    = ROB_DEPTH,
  parameter int unsigned IDX_W    = $clog2(DEPTH),
  parameter int unsigned PREG_W   = ROB_PREG_W,
  parameter int unsigned WB_PORTS = 4,
  parameter int unsigned COMMIT_W = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [31:0]                  alloc_instr_addr,
  input  logic [PREG_W-1:0]            alloc_dest,
  input  logic [PREG_W-1:0]            alloc_old_dest,
  input  logic [4:0]                   alloc_arch_dest,
  output logic [IDX_W-1:0]             alloc_idx,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]    wb_idx,
  input  logic [WB_PORTS*32-1:0]       wb_value,
`ifdef ROB_EXCEPTION_EN
  input  logic [WB_PORTS-1:0]          wb_exc,
  output logic                         commit_exc,
  output logic [31:0]                  commit_exc_addr,
`endif
  input  logic                         commit_ready,
  output logic [COMMIT_W-1:0]          commit_valid,
  output logic [COMMIT_W*PREG_W-1:0]   commit_dest,
  output logic [COMMIT_W*PREG_W-1:0]   commit_old_dest,
  output logic [COMMIT_W*5-1:0]        commit_arch_dest,
  output logic [COMMIT_W*32-1:0]       commit_value,
  output logic [COMMIT_W*32-1:0]       commit_instr_addr,
  input  logic                         flush_valid,
  input  logic [IDX_W-1:0]             flush_idx,
  output logic [IDX_W:0]               count,
  output logic                         empty
);

  localparam int unsigned CW    = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(COMMIT_W + 1);

  rob_entry_t          mem [DEPTH];
  logic [IDX_W-1:0]    head, tail;
  logic [DEPTH-1:0]    kill;
  logic                flush_fire, alloc_fire, exc_fire;
  logic [COMMIT_W-1:0] slot_rdy, slot_exc;
  logic [CNT_W-1:0]    commit_cnt;
  rob_entry_t          slot_ent [COMMIT_W];
  logic [IDX_W-1:0]    slot_idx [COMMIT_W];
  logic [IDX_W-1:0]    wb_tag   [WB_PORTS];

  assign alloc_idx   = tail;
  assign alloc_ready = (count != CW'(DEPTH));
  assign empty       = (count == '0);
  assign flush_fire  = flush_valid && mem[flush_idx].valid;
  assign alloc_fire  = alloc_valid && alloc_ready && !flush_fire && !exc_fire;

  always_comb begin
    for (int unsigned p = 0; p < WB_PORTS; p++) wb_tag[p] = wb_idx[p*IDX_W +: IDX_W];
  end

  // Commit window: the COMMIT_W entries starting at head, from registered state only.
  always_comb begin
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      slot_idx[k] = IDX_W'(ptr_add(32'(head), k, IDX_W));
      slot_ent[k] = mem[slot_idx[k]];
      slot_rdy[k] = slot_ent[k].valid && slot_ent[k].ready;
      slot_exc[k] = slot_ent[k].exc;
    end
  end

  rob_multiport_commit_select #(.COMMIT_W(COMMIT_W), .CNT_W(CNT_W)) u_commit_select (
    .slot_rdy     (slot_rdy),
    .slot_exc     (slot_exc),
    .commit_ready (commit_ready),
    .flush_valid  (flush_valid),
    .commit_valid (commit_valid),
    .commit_cnt   (commit_cnt)
  );

`ifdef ROB_EXCEPTION_EN
  assign exc_fire        = commit_valid[0] && slot_ent[0].exc;
  assign commit_exc      = exc_fire;
  assign commit_exc_addr = exc_fire ? slot_ent[0].pc : 32'd0;
`else
  assign exc_fire = 1'b0;
`endif

  always_comb begin
    commit_dest       = '0;
    commit_old_dest   = '0;
    commit_arch_dest  = '0;
    commit_value      = '0;
    commit_instr_addr = '0;
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      if (commit_valid[k]) begin
        commit_dest[k*PREG_W +: PREG_W]     = PREG_W'(slot_ent[k].dest);
        commit_old_dest[k*PREG_W +: PREG_W] = PREG_W'(slot_ent[k].old_dest);
        commit_arch_dest[k*5 +: 5]          = slot_ent[k].arch_dest;
        commit_value[k*32 +: 32]            = slot_ent[k].value;
        commit_instr_addr[k*32 +: 32]       = slot_ent[k].pc;
      end
    end
  end

  // Squash mask: valid entries strictly younger than flush_idx.
  always_comb begin
    kill = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      kill[i] = flush_fire && mem[i].valid &&
                (ptr_dist(i, 32'(head), IDX_W) > ptr_dist(32'(flush_idx), 32'(head), IDX_W));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Later ports overwrite earlier ones on a shared tag.
      for (int unsigned p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && mem[wb_tag[p]].valid && !kill[wb_tag[p]]) begin
          mem[wb_tag[p]].ready <= 1'b1;
          mem[wb_tag[p]].value <= wb_value[p*32 +: 32];
`ifdef ROB_EXCEPTION_EN
          mem[wb_tag[p]].exc   <= wb_exc[p];
`endif
        end
      end
      for (int unsigned k = 0; k < COMMIT_W; k++) begin
        if (commit_valid[k]) begin
          mem[slot_idx[k]].valid <= 1'b0;
          mem[slot_idx[k]].ready <= 1'b0;
          mem[slot_idx[k]].exc   <= 1'b0;
        end
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill[i] || exc_fire) begin
          mem[i].valid <= 1'b0;
          mem[i].ready <= 1'b0;
          mem[i].exc   <= 1'b0;
        end
      end
      if (alloc_fire) begin
        mem[tail] <= '{valid: 1'b1, ready: 1'b0, exc: 1'b0,
                       dest: ROB_PREG_W'(alloc_dest), old_dest: ROB_PREG_W'(alloc_old_dest),
                       arch_dest: alloc_arch_dest, pc: alloc_instr_addr, value: 32'd0};
      end

      if (flush_fire) begin
        tail  <= flush_idx + IDX_W'(1);
        count <= CW'(ptr_dist(32'(flush_idx), 32'(head), IDX_W) + 32'd1);
      end else if (exc_fire) begin
        head  <= tail;
        count <= '0;
      end else begin
        head  <= head + IDX_W'(commit_cnt);
        if (alloc_fire) tail <= tail + IDX_W'(1);
        count <= count + CW'(alloc_fire) - CW'(commit_cnt);
      end
    end
  end

endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
- Parametrised successor to the current 64-entry reorder buffer.
- Configurable depth, writeback port count and commit width.
- Writeback is indexed directly by ROB tag; no CAM search on physical destination.
- Adds branch-mispredict squash of younger entries.
- Sits between rename/dispatch (allocation), the execution units (writeback) and the register file/free list (commit).

Parameters:
- DEPTH, 64, number of entries; power of two, at least 4.
- IDX_W, log2(DEPTH), ROB tag width.
- PREG_W, 6, physical register tag width.
- WB_PORTS, 4, number of writeback ports.
- COMMIT_W, 2, maximum retirements per cycle; 1 to 4.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- alloc_valid  in  1  allocation request.
- alloc_ready  out  1  entry available (count < DEPTH).
- alloc_instr_addr  in  32  instruction PC.
- alloc_dest  in  PREG_W  new physical destination.
- alloc_old_dest  in  PREG_W  previous mapping, freed at commit.
- alloc_arch_dest  in  5  architectural destination.
- alloc_idx  out  IDX_W  tag assigned (= tail).
- wb_valid  in  WB_PORTS  writeback strobes.
- wb_idx  in  WB_PORTS*IDX_W  ROB tags, packed, port 0 in LSBs.
- wb_value  in  WB_PORTS*32  result values, packed.
- commit_ready  in  1  consumer accepts this cycle's commit group.
- commit_valid  out  COMMIT_W  per-slot commit; always a contiguous prefix from bit 0.
- commit_dest / commit_old_dest  out  COMMIT_W*PREG_W  per-slot tags.
- commit_arch_dest  out  COMMIT_W*5  per-slot architectural destination.
- commit_value  out  COMMIT_W*32  per-slot result.
- commit_instr_addr  out  COMMIT_W*32  per-slot PC.
- flush_valid  in  1  mispredict squash.
- flush_idx  in  IDX_W  tag of the mispredicted instruction; it survives, all younger entries die.
- count  out  IDX_W+1  occupancy.
- empty  out  1  count == 0.

Behaviour:
- **Reset:** all valid/ready bits 0; head = tail = 0; count = 0. Outputs: alloc_ready = 1, empty = 1, commit_valid = 0, all commit data 0.
- **Allocation:** alloc_valid & alloc_ready writes the entry at tail on the same edge (no delayed request register). Sets valid = 1 and ready = 0; tail increments mod DEPTH.
  - All DEPTH entries are usable; full/empty is decided by count, not by pointer compare.
- **Writeback:** wb_valid[p] on a valid entry sets ready = 1 and stores the value. Writeback to an invalid entry is ignored. If two ports hit the same tag, the highest port wins.
- **Commit, combinational from registered state only:**
  - Slot k is valid iff commit_ready and entries head..head+k (mod DEPTH) are all valid & ready, and flush_valid = 0.
  - Same-cycle writeback is not bypassed to commit.
- **Retirement:** on the edge, entries in the asserted commit_valid prefix are cleared. head advances by popcount(commit_valid) mod DEPTH.
- **count:** next = count + alloc_fire − commits.
  - Alloc and commit in the same cycle are both honoured.
  - alloc_ready uses registered count only; no credit is given for same-cycle commits.
- **Flush:** flush_valid with a valid flush_idx has priority over alloc and commit.
  - Clears valid on entries from flush_idx+1 up to tail−1.
  - tail <= flush_idx+1; count <= (flush_idx − head + 1) mod DEPTH, with the full case resolved to DEPTH.
  - Writebacks in the flush cycle are still applied to surviving entries.
  - Flush naming an invalid entry is ignored entirely.
- **Wrap:** all index arithmetic is mod DEPTH, using natural IDX_W-bit overflow.
- **Mid-operation reset:** state returns to reset values asynchronously.

Optional Feature:
- **Macro:** ROB_EXCEPTION_EN.
- **When defined:**
  - Adds input wb_exc[WB_PORTS], stored per entry.
  - Adds outputs commit_exc (1) and commit_exc_addr (32).
  - An excepting entry at head commits alone in slot 0 with commit_exc = 1 and commit_exc_addr = its PC.
  - An excepting entry at a younger slot truncates the group before it.
  - On the edge it retires, the whole ROB is cleared: head = tail, count = 0, alloc blocked that cycle.
- **When undefined:** no extra ports and no exception state; behaviour exactly as above.

Decomposition:
- **rob_pkg:**
  - DEPTH/IDX_W/PREG_W defaults.
  - Entry record: valid, ready, exc, dest, old_dest, arch_dest, pc, value.
  - Pointer increment/distance functions.
- **rob_commit_select sub-module:** combinational prefix-AND of valid&ready across COMMIT_W entries from head, plus exception truncation. Produces commit_valid and the popcount.

Test Plan:
- Allocate 3 (tags 0,1,2), writeback tag 1 then tag 0, commit_ready = 1 → cycle of tag-0 writeback shows commit_valid = 00; next cycle commit_valid = 11; tag 2 is held until written.
- Fill all 64 entries → alloc_ready = 0, count = 64; one commit plus alloc_valid in the same cycle → alloc refused, count = 63, alloc_ready = 1 next cycle.
- Head = 62, allocate 4 across the wrap, write back all, commit twice → tags 62,63 then 0,1 retire; head = 2, empty = 1.
- 10 entries (tags 0–9), flush_idx = 4 with alloc_valid and wb to tag 7 in the same cycle → tags 5–9 invalid, tail = 5, count = 5, alloc ignored, wb ignored; next alloc_idx = 5.
- Ports 0 and 3 write tag 2 with 0xAAAA/0x5555 → committed value 0x5555.
- ROB_EXCEPTION_EN: tag 1 written with wb_exc, tags 0–3 ready → commit tag 0 alone, then tag 1 alone with commit_exc = 1; then count = 0, empty = 1.
